arbiter8_rr: RTL
================

// Module: arbiter8_rr
// PURPOSE
//  Arbitrates one shared resource among 8 requesters with active-low request lines req_n[8:1].
//  Request-bit polarity and index numbering match the 8-to-3 priority encoder.
//  Issues a registered one-hot active-low grant and an encoded grant id.
//  Grant id encoding matches the encoder: requester k -> id k-1, so req_n[8] -> 3'b111.
//  The winner owns the resource until it drops its request or hits a hold limit.
//  Sits between requesting masters and the shared datapath/bus mux, which it selects via gnt_id.
// PARAMETERS
//  PRIORITY_MODE  0   0 = round-robin, 1 = fixed priority (req_n[8] highest, req_n[1] lowest)
//  MAX_HOLD       16  max consecutive grant cycles per ownership; 0 = unlimited; legal 0..255
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  req_n      in   8  [8:1] requests, bit low = requesting
//  gnt_n      out  8  [8:1] grant, one-hot low, all-high when no grant
//  gnt_id     out  3  index of granted requester minus 1; 3'b000 when gnt_valid = 0
//  gnt_valid  out  1  high while any grant is active
//  timeout    out  1  one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//  Clock and reset
//   - One clock. Reset is asynchronous and active-low.
//   - Reset values: gnt_n = 8'hFF, gnt_id = 0, gnt_valid = 0, timeout = 0.
//   - Reset values: state = IDLE, last_id = 3'b000 (requester 1), hold_cnt = 0, lock_mask = 0.
//   - Reset mid-grant drops the grant immediately, without waiting for a clock edge.
//  Outputs and request qualification
//   - All outputs are registered; no combinational path from req_n to any output.
//   - Eligible requests: elig[k] = ~req_n[k] & ~lock_mask[k].
//  State machine
//   IDLE
//    - At each edge, if any elig bit is set: pick the winner, register gnt_n/gnt_id/gnt_valid,
//      clear hold_cnt, go to GRANT. Latency is one edge from request sample to grant.
//    - Otherwise stay in IDLE.
//   GRANT
//    - Each edge, with the winner's req_n low: hold_cnt++.
//    - If MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1 at that edge: drop the grant,
//      pulse timeout for one cycle, set lock_mask[winner], go to IDLE.
//    - Winner's req_n sampled high: drop the grant at that edge, go to IDLE, no timeout.
//    - Requests from other requesters never preempt the current grant.
//    - A release (or timeout) plus pending requests gives exactly one all-high gnt_n cycle
//      before the next grant.
//   lock_mask[k]
//    - Cleared at any edge where req_n[k] is sampled high.
//    - A timed-out requester must deassert for at least one cycle before it is eligible again.
//  Winner selection
//   - Fixed mode: highest eligible index wins.
//   - Round-robin mode: search starts at the index just below last_id and descends,
//     wrapping 1 -> 8. last_id updates on each new grant.
//   - After reset, round-robin order equals fixed order, starting at req_n[8].
//  Width rules
//   - hold_cnt is 8 bits and saturates; it is never compared when MAX_HOLD = 0.
//  Boundary conditions
//   - All requests high in IDLE: outputs stay idle.
//   - Single requester: it is always granted, subject only to lockout.
//   - All 8 locked: remain IDLE until some requester deasserts.
// TESTING
//  1. Reset: rst_n low with req_n = 8'h00 -> gnt_n = 8'hFF, gnt_valid = 0, gnt_id = 0, timeout = 0.
//  2. Fixed (PRIORITY_MODE = 1): req_n = 8'b0011_1111 -> after one edge gnt_n = 8'b0111_1111,
//     gnt_id = 3'b111, gnt_valid = 1.
//  3. Round-robin: bench holds req_n = 8'h00; each owner drops its bit 3 cycles after its grant,
//     then re-asserts -> grant order 8,7,6,5,4,3,2,1,8 (gnt_id 7..0,7), one idle cycle between grants.
//  4. Timeout (MAX_HOLD = 4): req_n = 8'b1111_1110 held -> gnt_n = 8'b1111_1110 for 4 cycles,
//     timeout = 1 for 1 cycle, no regrant while held low.
//     After req_n[1] is high 1 cycle and low again -> regranted one edge later.
//  5. Async reset mid-grant: req_n[5] granted; rst_n falls between edges -> gnt_n = 8'hFF
//     immediately; after rst_n rises, arbitration restarts from req_n[8].
//  6. Simultaneous events: owner 6 releases on the same edge req_n[2] falls -> one cycle of
//     gnt_n = 8'hFF, then gnt_id = 3'b001. A concurrent req_n[8] during grant 2 does not preempt it.

Source files
------------

// File: rtl/arbiter8_rr_if.sv
// arbiter8_rr_if: request/grant bundle between requesting masters and the 8-way arbiter.
interface arbiter8_rr_if;
    logic [8:1] req_n;
    logic [8:1] gnt_n;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    modport master (output req_n, input gnt_n, gnt_id, gnt_valid, timeout);
    modport slave  (input req_n, output gnt_n, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/arbiter8_rr.sv
// arbiter8_rr: 8-way active-low arbiter, round-robin or fixed priority, with hold limit and lockout.
module arbiter8_rr #(
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_HOLD      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter8_rr_if.slave  bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    logic [0:0] state;
    logic [2:0] last_id;
    logic [7:0] hold_cnt;
    logic [8:1] lock_mask;
    logic [7:0] req_act;
    logic [7:0] elig;
    logic [2:0] start;
    logic [2:0] c;
    logic [2:0] win_id;
    logic       found;

    // Search descends from start, wrapping through id 0 back to 7.
    always_comb begin
        req_act = ~bus.req_n;
        elig    = ~bus.req_n & ~lock_mask;
        start   = (PRIORITY_MODE != 0) ? 3'd7 : last_id - 3'd1;
        c       = '0;
        win_id  = '0;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c = start - 3'(i);
            if (!found && elig[c]) begin
                win_id = c;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_id       <= '0;
            hold_cnt      <= '0;
            lock_mask     <= '0;
            bus.gnt_n     <= 8'hFF;
            bus.gnt_id    <= '0;
            bus.gnt_valid <= 1'b0;
            bus.timeout   <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            lock_mask   <= lock_mask & ~bus.req_n;
            if (state == IDLE) begin
                if (found) begin
                    state         <= GRANT;
                    last_id       <= win_id;
                    hold_cnt      <= '0;
                    bus.gnt_n     <= ~(8'b1 << win_id);
                    bus.gnt_id    <= win_id;
                    bus.gnt_valid <= 1'b1;
                end
            end else if (!req_act[bus.gnt_id] || (MAX_HOLD != 0 && hold_cnt == HOLD_LIM)) begin
                state         <= IDLE;
                bus.gnt_n     <= 8'hFF;
                bus.gnt_id    <= '0;
                bus.gnt_valid <= 1'b0;
                if (req_act[bus.gnt_id]) begin
                    bus.timeout <= 1'b1;
                    lock_mask   <= (lock_mask & ~bus.req_n) | (8'b1 << bus.gnt_id);
                end
            end else begin
                hold_cnt <= (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            end
        end
    end
endmodule
